sprite_fetch: RTL
=================

Name: sprite_fetch

Overview:
- Read-side master for the single-port sprite/background block RAMs (8-bit data, 16-bit address, 1-cycle registered read).
- Accepts a rectangle-fetch command (base, width, height, stride) and drives the RAM's en/we/addr.
- Absorbs the RAM read latency and streams the pixels in raster order over a valid/ready interface to the pixel compositor.

Parameters:
DATA_WIDTH, 8, RAM word / pixel width
ADDR_WIDTH, 16, RAM address width
DIM_WIDTH, 8, width of sprite width/height fields

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_base  in  ADDR_WIDTH  address of top-left pixel
cmd_width  in  DIM_WIDTH  pixels per row
cmd_height  in  DIM_WIDTH  rows
cmd_stride  in  ADDR_WIDTH  address increment between rows
sram_en  out  1  RAM enable, high only on cycles issuing a read
sram_we  out  1  RAM write enable, constant 0
sram_addr  out  ADDR_WIDTH  RAM read address
sram_data_i  out  DATA_WIDTH  RAM write data, constant 0
sram_data_o  in  DATA_WIDTH  RAM read data, valid the cycle after sram_en
pix_valid  out  1  pixel available
pix_ready  in  1  consumer accepts pixel
pix_data  out  DATA_WIDTH  pixel value
pix_last  out  1  qualifies final pixel of command
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset state: IDLE; FIFO and in-flight flags cleared.
- Reset values: cmd_ready=1, sram_en=0, sram_addr=0, pix_valid=0, pix_last=0, pix_data=0, busy=0, done=0. sram_we and sram_data_i are always 0.
- States:
  - IDLE: cmd_ready=1. On valid&ready, latch base/width/height/stride and set row=0, col=0, row_addr=base. Go to DONE if width==0 or height==0, else FETCH.
  - FETCH: issue reads; after the final address is issued go to DRAIN.
  - DRAIN: wait until the FIFO is empty, no read is in flight, and the last pixel has been handshaken; then DONE.
  - DONE: done=1 for one cycle; next IDLE.
- busy=1 in FETCH, DRAIN and DONE.
- Address generation: sram_addr = row_addr + col, computed modulo 2^ADDR_WIDTH (wraps, no error).
  - col increments per issued read.
  - At col==width-1: col returns to 0, row increments, row_addr += stride (also modulo).
- Read latency: a read issued in cycle N (sram_en=1) lands in sram_data_o in cycle N+1 and is written into a 2-entry output FIFO at the end of cycle N+1.
- pix_* are driven from the FIFO head, registered. With an empty FIFO the first pixel appears 3 cycles after the command handshake.
- Flow control: issue a read in cycle N only if (fifo_count + inflight − pop_N) < 2, where pop_N = pix_valid&pix_ready in cycle N. This must never overflow the FIFO.
- Throughput: with pix_ready held high, 1 pixel/cycle sustained and no bubbles after the first pixel.
- Backpressure: pix_ready low freezes pix_data/pix_valid/pix_last. Issue stalls once 2 words are owed.
- pix_last=1 exactly on pixel number width*height; it travels with the FIFO entry.
- Zero-size command: no sram_en, no pixels, done pulses 1 cycle after IDLE→DONE.
- A new command is accepted only in IDLE. cmd_* values are ignored while busy.
- Reset mid-operation: the FSM returns to IDLE next cycle, the FIFO is flushed, in-flight data is discarded, and no done pulse is produced.

Test Plan:
- Basic fetch: base=0x0100, width=2, height=2, stride=320, pix_ready=1, RAM preloaded addr→addr[7:0].
  - sram_addr is 0x0100, 0x0101, 0x0240, 0x0241 on consecutive cycles 1–4 after the handshake.
  - pix_data is 0x00, 0x01, 0x40, 0x41 on cycles 3–6; pix_last on 0x41; done on cycle 7.
- Backpressure: same command with pix_ready low cycles 3–8.
  - pix_data holds 0x00.
  - At most 2 reads issued beyond the last popped pixel; sram_en=0 thereafter.
  - After release all 4 pixels arrive in order, none lost or duplicated.
- Wrap: base=0xFFFE, width=4, height=1 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Zero size: width=0, height=5 → sram_en never 1, pix_valid never 1, done pulses once, back to IDLE.
- Reset mid-stream: width=8, height=8; assert reset at pixel 10 for 1 cycle.
  - Next cycle: pix_valid=0, busy=0, cmd_ready=1, no done pulse.
  - A following 1×1 command at base 0x0005 returns 0x05 only.
- Random throttle: width=16, height=16, stride=64, random pix_ready.
  - Output is exactly 256 pixels matching a raster-order model, pix_last only on the 256th.
  - sram_we always 0.

Source files
------------

// File: rtl/sprite_fetch_if.sv
// Bundle of the command, RAM and pixel-stream signals around the sprite fetcher.
// master is the fetcher's view; slave is the view of whatever surrounds it.
interface sprite_fetch_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [DIM_WIDTH-1:0]  cmd_width;
  logic [DIM_WIDTH-1:0]  cmd_height;
  logic [ADDR_WIDTH-1:0] cmd_stride;

  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_data_i;
  logic [DATA_WIDTH-1:0] sram_data_o;

  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_last;

  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_base, cmd_width, cmd_height, cmd_stride,
    output cmd_ready,
    output sram_en, sram_we, sram_addr, sram_data_i,
    input  sram_data_o,
    output pix_valid, pix_data, pix_last,
    input  pix_ready,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_width, cmd_height, cmd_stride,
    input  cmd_ready,
    input  sram_en, sram_we, sram_addr, sram_data_i,
    output sram_data_o,
    input  pix_valid, pix_data, pix_last,
    output pix_ready,
    input  busy, done
  );
endinterface

// File: rtl/sprite_fetch.sv
// Rectangle fetcher: walks a strided rectangle in a 1-cycle-latency block RAM
// and streams the pixels in raster order through a 2-entry skid FIFO.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// FETCH | issuing reads while fewer than two words are owed downstream
// DRAIN | all reads issued, waiting for the last pixel to be taken
// DONE  | one-cycle completion pulse
module sprite_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input logic            clk,
  input logic            reset,
  sprite_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  width_q, width_d;
  logic [DIM_WIDTH-1:0]  height_q, height_d;
  logic [DIM_WIDTH-1:0]  col_q, col_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic                  fifo_last_q [2];
  logic                  fifo_last_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  row_end;
  logic                  last_addr;
  logic [2:0]            owed;

  // Words owed = stored + in flight, minus the one leaving this cycle.
  assign push      = inflight_q;
  assign pop       = (count_q != 2'd0) && bus.pix_ready;
  assign owed      = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign row_end   = (col_q == width_q - DIM_WIDTH'(1));
  assign last_addr = row_end && (row_q == height_q - DIM_WIDTH'(1));
  assign issue     = (state_q == S_FETCH) && (owed < 3'd2);

  always_comb begin
    state_d         = state_q;
    width_d         = width_q;
    height_d        = height_q;
    col_d           = col_q;
    row_d           = row_q;
    stride_d        = stride_q;
    row_addr_d      = row_addr_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = issue;
    inflight_last_d = issue && last_addr;
    count_d         = count_q + 2'(push) - 2'(pop);

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          width_d    = bus.cmd_width;
          height_d   = bus.cmd_height;
          stride_d   = bus.cmd_stride;
          row_addr_d = bus.cmd_base;
          col_d      = '0;
          row_d      = '0;
          if ((bus.cmd_width == '0) || (bus.cmd_height == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (issue) begin
          if (row_end) begin
            col_d      = '0;
            row_d      = row_q + DIM_WIDTH'(1);
            row_addr_d = row_addr_q + stride_q;
          end else begin
            col_d = col_q + DIM_WIDTH'(1);
          end
          if (last_addr) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The tagged final word being taken means nothing else is owed.
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.sram_data_o;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      width_q         <= '0;
      height_q        <= '0;
      col_q           <= '0;
      row_q           <= '0;
      stride_q        <= '0;
      row_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '{default: 1'b0};
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      width_q         <= width_d;
      height_q        <= height_d;
      col_q           <= col_d;
      row_q           <= row_d;
      stride_q        <= stride_d;
      row_addr_q      <= row_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.sram_en     = issue;
  assign bus.sram_we     = 1'b0;
  assign bus.sram_addr   = issue ? (row_addr_q + ADDR_WIDTH'(col_q)) : '0;
  assign bus.sram_data_i = '0;
  assign bus.pix_valid   = (count_q != 2'd0);
  assign bus.pix_data    = (count_q != 2'd0) ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.pix_last    = (count_q != 2'd0) && fifo_last_q[rd_ptr_q];
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == 2'd2)));

endmodule
